// File: rtl/line_mem_responder.sv
// Memory-side responder for 256-bit cache-line requests, backed by a 32-bit synchronous word RAM.
// Each line moves as 8 sequential word beats; word k of a line lives at RAM address {line, k}.
module line_mem_responder #(
  parameter int    LINE_AW   = 10,
  parameter string INIT_FILE = ""
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         req_read,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [255:0] req_write_data,
  output logic         resp_done,
  output logic [255:0] resp_read_data,
  output logic         busy
);

  localparam int RAM_AW = LINE_AW + 3;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           beat_reg;
  logic [LINE_AW-1:0]   index_reg;
  logic [255:0]         wdata_reg;
  logic [31:0]          mem [2**RAM_AW];
  logic [31:0]          ram_q;
  logic [RAM_AW-1:0]    ram_addr;
  logic [31:0]          wr_word;
  logic                 ram_we;
  logic                 cap_en;
  logic [2:0]           cap_beat;
  logic [31:0]          rd_words [8];

  // Offset bits and bits above the line index are don't-care (addresses alias).
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:LINE_AW+5], req_addr[4:0]};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_write)     state_next = WR;
               else if (req_read) state_next = RD;
      RD:      if (beat_reg == 3'd7) state_next = RD_WAIT;
      RD_WAIT: state_next = DONE;
      WR:      if (beat_reg == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_done = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      index_reg <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_reg <= '0;
          if (req_write || req_read) index_reg <= req_addr[LINE_AW+4:5];
          if (req_write)             wdata_reg <= req_write_data;
        end
        RD, WR:  beat_reg <= beat_reg + 3'd1;
        default: ;
      endcase
    end
  end

  assign ram_addr = {index_reg, beat_reg};
  assign ram_we   = (state_reg == WR);
  assign wr_word  = wdata_reg[{beat_reg, 5'd0} +: 32];

  always_ff @(posedge sys_clk) begin
    if (ram_we) mem[ram_addr] <= wr_word;
    ram_q <= mem[ram_addr];
  end

  // RAM data trails the issued beat by one cycle; beat_reg has already advanced (and wraps to 0 in RD_WAIT).
  assign cap_en   = ((state_reg == RD) && (beat_reg != 3'd0)) || (state_reg == RD_WAIT);
  assign cap_beat = beat_reg - 3'd1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rd_words
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)                                   rd_words[gi] <= '0;
      else if (cap_en && (cap_beat == 3'(gi)))      rd_words[gi] <= ram_q;
    end
    assign resp_read_data[gi*32 +: 32] = rd_words[gi];
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a line-indexed reference model feeds a scoreboard queue
// that is popped and compared whenever resp_done pulses.
module tb_line_mem_responder;

  logic         sys_clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_read = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [255:0] req_write_data = '0;
  logic         resp_done;
  logic [255:0] resp_read_data;
  logic         busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [255:0] model [int];
  logic [255:0] exp_q [$];
  bit           is_rd_q [$];
  logic [255:0] saved;

  line_mem_responder #(.LINE_AW(10), .INIT_FILE("")) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_write_data(req_write_data), .resp_done(resp_done),
    .resp_read_data(resp_read_data), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and push its expected outcome; if called in a DONE cycle the
  // request is held through the following IDLE cycle, which accepts it.
  task automatic start(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] d);
    int idx;
    bit chained;
    chained = resp_done;
    idx = int'((a >> 5) & 32'd1023);
    req_read = rd; req_write = wr; req_addr = a; req_write_data = d;
    if (wr) begin
      model[idx] = d;
      is_rd_q.push_back(1'b0);
      exp_q.push_back('0);
    end else begin
      if (!model.exists(idx)) model[idx] = '0;
      is_rd_q.push_back(1'b1);
      exp_q.push_back(model[idx]);
    end
    if (chained) begin
      @(negedge sys_clk);
      check("idle_gap_busy", {255'd0, busy}, 256'd0);
    end
  endtask

  task automatic finish(input int lat, input bit rel,
                        input logic [255:0] hold = '0, input bit chk_hold = 1'b0);
    int n;
    bit rdop;
    logic [255:0] e;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
      check("busy_active", {255'd0, busy}, 256'd1);
      if (chk_hold) check("rdata_stable", resp_read_data, hold);
    end while (!resp_done && n < 40);
    check("done_cycle", 256'(n), 256'(lat));
    if (rel) begin req_read = 1'b0; req_write = 1'b0; end
    rdop = is_rd_q.pop_front();
    e = exp_q.pop_front();
    if (rdop) check("read_data", resp_read_data, e);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_done", {255'd0, resp_done}, 256'd0);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_rdata", resp_read_data, 256'd0);
    rst_n = 1'b1;

    // Write then read one line
    @(negedge sys_clk); start(0, 1, 32'h0000_0040, line_of(32'hA5A5_0000)); finish(9, 1);
    @(negedge sys_clk); start(1, 0, 32'h0000_0040, '0); finish(10, 1);

    // Byte offset and aliasing above the line index
    @(negedge sys_clk); start(1, 0, 32'h0000_005C, '0); finish(10, 1);
    @(negedge sys_clk); start(1, 0, 32'h0000_8040, '0); finish(10, 1);

    // A write to another line leaves the read data untouched
    saved = resp_read_data;
    @(negedge sys_clk); start(0, 1, 32'h0000_0400, line_of(32'h1234_0000)); finish(9, 1, saved, 1'b1);
    @(negedge sys_clk);
    check("done_one_cycle", {255'd0, resp_done}, 256'd0);
    check("idle_busy", {255'd0, busy}, 256'd0);
    check("rdata_after_wr", resp_read_data, saved);

    // Read and write together: write wins, single completion
    @(negedge sys_clk); start(1, 1, 32'h0000_0080, {8{32'h1111_1111}}); finish(9, 1);
    @(negedge sys_clk); check("no_extra_done", {255'd0, resp_done}, 256'd0);
    start(1, 0, 32'h0000_0080, '0); finish(10, 1);

    // Back-to-back alternating write/read on lines 0..3
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      start(0, 1, 32'(k * 32), line_of(32'hC0DE_0000 + 32'(k << 8))); finish(9, 1'b0);
      start(1, 0, 32'(k * 32), '0); finish(10, k == 3);
    end
    @(negedge sys_clk); check("b2b_idle_done", {255'd0, resp_done}, 256'd0);

    // Reset during beat 4 of a write leaves beats 0-3 committed
    @(negedge sys_clk); start(0, 1, 32'h0000_0200, '0); finish(9, 1);
    @(negedge sys_clk); start(0, 1, 32'h0000_0200, {8{32'hFFFF_FFFF}});
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b0; req_write = 1'b0;
    #1;
    check("mid_rst_busy", {255'd0, busy}, 256'd0);
    check("mid_rst_done", {255'd0, resp_done}, 256'd0);
    check("mid_rst_rdata", resp_read_data, 256'd0);
    void'(is_rd_q.pop_front());
    void'(exp_q.pop_front());
    model[16] = {128'd0, {4{32'hFFFF_FFFF}}};
    @(negedge sys_clk); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      check("no_done_after_rst", {255'd0, resp_done}, 256'd0);
    end
    start(1, 0, 32'h0000_0200, '0); finish(10, 1);

    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
